// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the two-master memory bus arbiter
package bus_pkg;

    // Arbiter ownership state: nobody, master 0, or master 1 holds the bus
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int BUS_ADDR_W_DEF  = 32;
    localparam int BUS_DATA_W_DEF  = 32;
    localparam int BUS_TIMEOUT_DEF = 256;

    // Value returned on rdata to any master that does not own the bus
    localparam logic [31:0] BUS_IDLE_DATA = 32'h0000_0000;

    // Ownership state for master index k
    function automatic arb_state_t own_of(input logic k);
        return k ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin selector
//
// Ports:
//   req0, req1 : request lines
//   last       : index of the requester granted most recently
//   gnt        : selected index (only meaningful when valid)
//   valid      : at least one request present
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        // On a tie the requester that did not win last time goes next
        if (req0 && req1) begin
            gnt = ~last;
        end else begin
            gnt = req1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter for the shared physical memory bus
//
// Master 0 is instruction fetch, master 1 is data load/store. The grant is
// registered and held for a whole transaction; address/data/strobes and the
// rdata/ready return path are pure combinational muxes selected by the grant.
//
// Optional build macro: BUS_ARB_TIMEOUT_EN
//   defined   - an owner that sees no bus_ready for TIMEOUT_CYCLES owned cycles
//               is completed with mN_ready=1, mN_err=1, rdata=0
//   undefined - no counter, mN_err is always 0
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mN_addr/wdata/rd/wr           master N request (held until mN_ready)
//   mN_rdata/ready/err            master N response (zero unless N owns the bus)
//   bus_addr/wdata/rd/wr          to slaves (zero while idle)
//   bus_rdata, bus_ready          OR of all slave responses
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W_DEF,
    parameter int DATA_W         = BUS_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_rd,
    input  logic              m0_wr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_err,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_rd,
    input  logic              m1_wr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_err,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rd,
    output logic              bus_wr,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(BUS_IDLE_DATA);

    arb_state_t state;
    arb_state_t nxt_state;
    logic       last;
    logic       nxt_last;

    logic req0;
    logic req1;
    logic owned;
    logic owner;      // index of the owning master, valid when owned
    logic req_own;
    logic req_oth;
    logic timeout;
    logic rdy_eff;    // slave ready or forced timeout completion
    logic done;
    logic pick_gnt;
    logic pick_valid;

    assign req0    = m0_rd | m0_wr;
    assign req1    = m1_rd | m1_wr;
    assign owned   = (state != IDLE);
    assign owner   = (state == OWN1);
    assign req_own = owner ? req1 : req0;
    assign req_oth = owner ? req0 : req1;
    assign rdy_eff = bus_ready | timeout;
    assign done    = owned & rdy_eff & req_own;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        nxt_state = state;
        nxt_last  = last;
        case (state)
            IDLE: begin
                // bus_ready is ignored here; nothing is outstanding
                if (pick_valid) begin
                    nxt_state = own_of(pick_gnt);
                end
            end
            default: begin
                if (done) begin
                    nxt_last = owner;
                    // The owner still holds its request on the completion
                    // cycle, so it keeps the bus unless the other master waits.
                    if (req_oth) begin
                        nxt_state = own_of(~owner);
                    end
                end else if (!req_own) begin
                    // Owner abandoned its request: hand over without touching last
                    nxt_state = req_oth ? own_of(~owner) : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= nxt_state;
            last  <= nxt_last;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] to_cnt;

    assign timeout = owned & ~bus_ready & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts owned cycles of the current transaction; any change of owner
    // (including a fresh grant from idle) or a completion restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!owned || done || (nxt_state != state)) begin
            to_cnt <= '0;
        end else if (!bus_ready) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Output muxes follow the registered state, so an asynchronous reset
    // clears every bus and response output as soon as state returns to IDLE.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        m0_rdata  = IDLE_DATA;
        m0_ready  = 1'b0;
        m0_err    = 1'b0;
        m1_rdata  = IDLE_DATA;
        m1_ready  = 1'b0;
        m1_err    = 1'b0;
        case (state)
            OWN0: begin
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
                bus_rd    = m0_rd;
                bus_wr    = m0_wr;
                m0_rdata  = timeout ? IDLE_DATA : bus_rdata;
                m0_ready  = rdy_eff & req0;
                m0_err    = timeout & req0;
            end
            OWN1: begin
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
                bus_rd    = m1_rd;
                bus_wr    = m1_wr;
                m1_rdata  = timeout ? IDLE_DATA : bus_rdata;
                m1_ready  = rdy_eff & req1;
                m1_err    = timeout & req1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int TO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] W0 = 32'h1111_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        m0_rd, m0_wr, m1_rd, m1_wr, bus_ready;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic        m0_ready, m0_err, m1_ready, m1_err, bus_rd, bus_wr;

    int nchecks = 0;
    int nerrs   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rd     (m0_rd),
        .m0_wr     (m0_wr),
        .m0_rdata  (m0_rdata),
        .m0_ready  (m0_ready),
        .m0_err    (m0_err),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rd     (m1_rd),
        .m1_wr     (m1_wr),
        .m1_rdata  (m1_rdata),
        .m1_ready  (m1_ready),
        .m1_err    (m1_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    typedef struct {
        bit          rst;
        bit          r0, w0, r1, w1, rdy;
        logic [31:0] a0, a1, wd1, rdat;
        bit          e_rd, e_wr, e_r0, e_r1;
        logic [31:0] e_addr, e_wd, e_d0, e_d1;
    } vec_t;

    vec_t tv[$];
    vec_t v;

    // reference model: owner is -1 (nobody), 0 or 1
    int          own, last_m, cnt_m;
    bit          q0, q1, rk, ro, to;
    logic [31:0] ea, ewd, ed0, ed1;
    bit          erd, ewr, er0, er1, ee0, ee1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_addr = '0; m0_wdata = W0; m0_rd = 0; m0_wr = 0;
        m1_addr = '0; m1_wdata = '0; m1_rd = 0; m1_wr = 0;
        bus_rdata = '0; bus_ready = 0;
    endtask

    // Reset with busy inputs: every output must still read zero
    task automatic do_reset();
        rst_n = 0;
        m0_rd = 1; m1_wr = 1; bus_ready = 1; bus_rdata = 32'h5A5A_5A5A;
        m0_addr = 32'h40; m1_addr = 32'h50;
        #2;
        chkb("rst bus_rd", bus_rd, 1'b0);
        chkb("rst bus_wr", bus_wr, 1'b0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chkb("rst m0_ready", m0_ready, 1'b0);
        chkb("rst m1_ready", m1_ready, 1'b0);
        chk("rst m0_rdata", m0_rdata, 32'h0);
        chk("rst m1_rdata", m1_rdata, 32'h0);
        chkb("rst m0_err", m0_err, 1'b0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        own = -1; last_m = 1; cnt_m = 0;
    endtask

    task automatic add(input bit rst, input logic [4:0] ctl,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd1, input logic [31:0] rdat,
                       input logic [3:0] ef, input logic [31:0] eaddr,
                       input logic [31:0] ewdat, input logic [31:0] d0,
                       input logic [31:0] d1);
        vec_t t;
        t.rst = rst;
        {t.r0, t.w0, t.r1, t.w1, t.rdy} = ctl;
        t.a0 = a0; t.a1 = a1; t.wd1 = wd1; t.rdat = rdat;
        {t.e_rd, t.e_wr, t.e_r0, t.e_r1} = ef;
        t.e_addr = eaddr; t.e_wd = ewdat; t.e_d0 = d0; t.e_d1 = d1;
        tv.push_back(t);
    endtask

    initial begin
        clear_inputs();
        own = -1; last_m = 1; cnt_m = 0;

        // ctl = {r0,w0,r1,w1,rdy}; flags = {bus_rd,bus_wr,m0_ready,m1_ready}
        // m0 alone, slave with one cycle of read latency
        add(1, 5'b10000, 32'h10, 32'h0, 32'h0, 32'h0,        4'b0000, 32'h0,  32'h0, 32'h0,        32'h0);
        add(0, 5'b10000, 32'h10, 32'h0, 32'h0, 32'h0,        4'b1000, 32'h10, W0,    32'h0,        32'h0);
        add(0, 5'b10001, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 4'b1010, 32'h10, W0,    32'hDEADBEEF, 32'h0);
        add(0, 5'b00000, 32'h10, 32'h0, 32'h0, 32'h0,        4'b0000, 32'h10, W0,    32'h0,        32'h0);
        add(0, 5'b00001, 32'h10, 32'h0, 32'h0, 32'h77,       4'b0000, 32'h0,  32'h0, 32'h0,        32'h0);
        // simultaneous requests after reset, m0 first, no bubble into m1 write
        add(1, 5'b10010, 32'h20, 32'h44, 32'hCAFEF00D, 32'h0,       4'b0000, 32'h0,  32'h0,        32'h0,       32'h0);
        add(0, 5'b10011, 32'h20, 32'h44, 32'hCAFEF00D, 32'h12345678, 4'b1010, 32'h20, W0,           32'h12345678, 32'h0);
        add(0, 5'b00010, 32'h20, 32'h44, 32'hCAFEF00D, 32'h0,       4'b0100, 32'h44, 32'hCAFEF00D, 32'h0,       32'h0);
        add(0, 5'b00011, 32'h20, 32'h44, 32'hCAFEF00D, 32'h0,       4'b0101, 32'h44, 32'hCAFEF00D, 32'h0,       32'h0);
        add(0, 5'b00000, 32'h20, 32'h44, 32'hCAFEF00D, 32'h0,       4'b0000, 32'h44, 32'hCAFEF00D, 32'h0,       32'h0);
        // m1 back-to-back, m0 joins and wins at the next m1 completion
        add(0, 5'b00100, 32'h0,  32'h100, 32'h0, 32'h0,  4'b0000, 32'h0,   32'h0, 32'h0,  32'h0);
        add(0, 5'b00101, 32'h0,  32'h100, 32'h0, 32'hA1, 4'b1001, 32'h100, 32'h0, 32'h0,  32'hA1);
        add(0, 5'b00101, 32'h0,  32'h104, 32'h0, 32'hA2, 4'b1001, 32'h104, 32'h0, 32'h0,  32'hA2);
        add(0, 5'b10100, 32'h30, 32'h108, 32'h0, 32'h0,  4'b1000, 32'h108, 32'h0, 32'h0,  32'h0);
        add(0, 5'b10101, 32'h30, 32'h108, 32'h0, 32'hA3, 4'b1001, 32'h108, 32'h0, 32'h0,  32'hA3);
        add(0, 5'b10101, 32'h30, 32'h10C, 32'h0, 32'hB0, 4'b1010, 32'h30,  W0,    32'hB0, 32'h0);
        add(0, 5'b00101, 32'h30, 32'h10C, 32'h0, 32'hA4, 4'b1001, 32'h10C, 32'h0, 32'h0,  32'hA4);
        add(0, 5'b00000, 32'h30, 32'h10C, 32'h0, 32'h0,  4'b0000, 32'h10C, 32'h0, 32'h0,  32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            if (v.rst) do_reset();
            m0_rd = v.r0; m0_wr = v.w0; m1_rd = v.r1; m1_wr = v.w1;
            bus_ready = v.rdy; m0_addr = v.a0; m1_addr = v.a1;
            m0_wdata = W0; m1_wdata = v.wd1; bus_rdata = v.rdat;
            #3;
            chkb($sformatf("row%0d bus_rd", i), bus_rd, v.e_rd);
            chkb($sformatf("row%0d bus_wr", i), bus_wr, v.e_wr);
            chk($sformatf("row%0d bus_addr", i), bus_addr, v.e_addr);
            chk($sformatf("row%0d bus_wdata", i), bus_wdata, v.e_wd);
            chkb($sformatf("row%0d m0_ready", i), m0_ready, v.e_r0);
            chkb($sformatf("row%0d m1_ready", i), m1_ready, v.e_r1);
            chk($sformatf("row%0d m0_rdata", i), m0_rdata, v.e_d0);
            chk($sformatf("row%0d m1_rdata", i), m1_rdata, v.e_d1);
            chkb($sformatf("row%0d m0_err", i), m0_err, 1'b0);
            chkb($sformatf("row%0d m1_err", i), m1_err, 1'b0);
            tick();
        end

        // Randomised traffic against the rule-level model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int k0, k1;
            k0 = $urandom_range(0, 9);
            k1 = $urandom_range(0, 9);
            m0_rd = (k0 >= 3 && k0 <= 6) || k0 == 9;
            m0_wr = (k0 >= 7);
            m1_rd = (k1 >= 3 && k1 <= 6) || k1 == 9;
            m1_wr = (k1 >= 7);
            bus_ready = ($urandom_range(0, 3) == 0);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom; bus_rdata = $urandom;
            #3;
            q0 = m0_rd | m0_wr;
            q1 = m1_rd | m1_wr;
            ea = '0; ewd = '0; erd = 0; ewr = 0;
            ed0 = '0; ed1 = '0; er0 = 0; er1 = 0; ee0 = 0; ee1 = 0; to = 0;
            if (own >= 0) begin
                to = TO_EN && (cnt_m == TO - 1) && !bus_ready;
                rk = (own == 0) ? q0 : q1;
                ea  = (own == 0) ? m0_addr : m1_addr;
                ewd = (own == 0) ? m0_wdata : m1_wdata;
                erd = (own == 0) ? m0_rd : m1_rd;
                ewr = (own == 0) ? m0_wr : m1_wr;
                if (own == 0) begin
                    ed0 = to ? 32'h0 : bus_rdata; er0 = (bus_ready || to) && rk; ee0 = to && rk;
                end else begin
                    ed1 = to ? 32'h0 : bus_rdata; er1 = (bus_ready || to) && rk; ee1 = to && rk;
                end
            end
            chk($sformatf("rand%0d bus_addr", c), bus_addr, ea);
            chk($sformatf("rand%0d bus_wdata", c), bus_wdata, ewd);
            chkb($sformatf("rand%0d bus_rd", c), bus_rd, erd);
            chkb($sformatf("rand%0d bus_wr", c), bus_wr, ewr);
            chk($sformatf("rand%0d m0_rdata", c), m0_rdata, ed0);
            chk($sformatf("rand%0d m1_rdata", c), m1_rdata, ed1);
            chkb($sformatf("rand%0d m0_ready", c), m0_ready, er0);
            chkb($sformatf("rand%0d m1_ready", c), m1_ready, er1);
            chkb($sformatf("rand%0d m0_err", c), m0_err, ee0);
            chkb($sformatf("rand%0d m1_err", c), m1_err, ee1);
            if (own < 0) begin
                if (q0 && q1) own = 1 - last_m;
                else if (q0)  own = 0;
                else if (q1)  own = 1;
                cnt_m = 0;
            end else begin
                rk = (own == 0) ? q0 : q1;
                ro = (own == 0) ? q1 : q0;
                if ((bus_ready || to) && rk) begin
                    last_m = own;
                    if (ro) own = 1 - own;
                    cnt_m = 0;
                end else if (!rk) begin
                    own = ro ? 1 - own : -1;
                    cnt_m = 0;
                end else begin
                    cnt_m++;
                end
            end
            tick();
        end

        // Reset in the middle of an m1 transaction, then a tie goes to m0
        do_reset();
        m1_rd = 1; m1_addr = 32'h200;
        tick();
        #2;
        chkb("mid bus_rd before reset", bus_rd, 1'b1);
        chk("mid bus_addr before reset", bus_addr, 32'h200);
        bus_ready = 1;
        #1 rst_n = 0;
        #1;
        chkb("mid bus_rd async drop", bus_rd, 1'b0);
        chk("mid bus_addr async drop", bus_addr, 32'h0);
        chkb("mid m1_ready in reset", m1_ready, 1'b0);
        @(posedge clk);
        #3 rst_n = 1;
        bus_ready = 0;
        m0_rd = 1; m0_addr = 32'h300;
        m1_rd = 1; m1_addr = 32'h204;
        #1;
        chkb("post reset idle bus_rd", bus_rd, 1'b0);
        tick();
        #2;
        chk("post reset tie to m0", bus_addr, 32'h300);
        chkb("post reset tie bus_rd", bus_rd, 1'b1);
        clear_inputs();

`ifdef BUS_ARB_TIMEOUT_EN
        // Unmapped address with m1 waiting: forced completion on 8th owned cycle
        do_reset();
        m0_rd = 1; m0_addr = 32'h8000_0000; bus_rdata = 32'hFFFF_0000;
        tick();
        m1_rd = 1; m1_addr = 32'h400;
        for (int cyc = 1; cyc <= TO; cyc++) begin
            #2;
            if (cyc < TO) begin
                chkb($sformatf("to cyc%0d m0_ready", cyc), m0_ready, 1'b0);
                chkb($sformatf("to cyc%0d m0_err", cyc), m0_err, 1'b0);
            end else begin
                chkb("to m0_ready", m0_ready, 1'b1);
                chkb("to m0_err", m0_err, 1'b1);
                chk("to m0_rdata", m0_rdata, 32'h0);
                chkb("to m1_ready", m1_ready, 1'b0);
            end
            tick();
        end
        #2;
        chk("to handover bus_addr", bus_addr, 32'h400);
        chkb("to handover m0_err", m0_err, 1'b0);
        clear_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
